// File: rtl/ulpi_pkg.sv
// rtl/ulpi_pkg.sv - shared types for the ULPI register-access arbiter
// Purpose: ULPI register address width/type and the arbiter FSM state encoding.
// Ports: none (package).
package ulpi_pkg;

  localparam int ULPI_REG_ADDR_W = 6;

  typedef logic [ULPI_REG_ADDR_W-1:0] ulpi_reg_addr_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ulpi_rr_arb.sv
// rtl/ulpi_rr_arb.sv - combinational round-robin grant selector
// Purpose: pick the first asserted request at or above ptr, wrapping at N_REQ.
// Ports:
//   req       in  N_REQ  request vector
//   ptr       in  IDX_W  search start index
//   grant     out N_REQ  one-hot grant (zero when no request)
//   grant_idx out IDX_W  index of the granted requester
//   any_req   out 1      at least one request asserted
module ulpi_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  // One extra bit so ptr + offset can exceed N_REQ-1 before the wrap.
  logic [IDX_W:0]   pos;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    pos       = '0;
    idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(N_REQ)) begin
        pos = pos - (IDX_W+1)'(N_REQ);
      end
      idx = pos[IDX_W-1:0];
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/ulpi_reg_arbiter.sv
// rtl/ulpi_reg_arbiter.sv - round-robin arbiter of register accesses onto one ULPI link
// Purpose: serialise N_REQ requesters onto the ulpi_link register port with timeout abort.
// Ports:
//   clk, reset_n                          clock, async active-low reset
//   req_valid/addr/wdata/read_nwrite      per-requester request (held until req_done)
//   req_done, req_err, req_rdata          completion pulse, timeout flag, read data
//   busy                                  high whenever the FSM is not IDLE
//   reg_addr/data_write/read_nwrite       latched transaction to ulpi_link
//   reg_enable                            one-cycle start strobe to ulpi_link
//   reg_done, reg_data_read               completion and read data from ulpi_link
import ulpi_pkg::*;

module ulpi_reg_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [N_REQ-1:0]                        req_valid,
  input  logic [N_REQ-1:0][ULPI_REG_ADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0][7:0]                   req_wdata,
  input  logic [N_REQ-1:0]                        req_read_nwrite,
  output logic [N_REQ-1:0]                        req_done,
  output logic                                    req_err,
  output logic [7:0]                              req_rdata,
  output logic                                    busy,
  output ulpi_reg_addr_t                          reg_addr,
  output logic [7:0]                              reg_data_write,
  output logic                                    reg_read_nwrite,
  output logic                                    reg_enable,
  input  logic                                    reg_done,
  input  logic [7:0]                              reg_data_read
);

  localparam int         IDX_W       = $clog2(N_REQ);
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [N_REQ-1:0] grant_oh;
  logic [7:0]       wait_cnt;
  logic [7:0]       cnt_inc;
  logic             timeout_hit;
  logic [IDX_W-1:0] next_ptr;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  ulpi_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Saturating WAIT counter; the abort fires on the WAIT cycle whose
  // increment would reach the limit, so exactly TIMEOUT_CYCLES WAIT cycles run.
  assign cnt_inc     = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
  assign timeout_hit = (cnt_inc == TIMEOUT_LIM);
  assign next_ptr    = (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
  assign busy        = (state != ARB_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ARB_IDLE;
      ptr             <= '0;
      grant_idx       <= '0;
      grant_oh        <= '0;
      wait_cnt        <= '0;
      req_done        <= '0;
      req_err         <= 1'b0;
      req_rdata       <= '0;
      reg_addr        <= '0;
      reg_data_write  <= '0;
      reg_read_nwrite <= 1'b0;
      reg_enable      <= 1'b0;
    end else begin
      req_done   <= '0;
      req_err    <= 1'b0;
      req_rdata  <= '0;
      reg_enable <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (arb_any) begin
            grant_idx       <= arb_idx;
            grant_oh        <= arb_grant;
            reg_addr        <= req_addr[arb_idx];
            reg_data_write  <= req_wdata[arb_idx];
            reg_read_nwrite <= req_read_nwrite[arb_idx];
            reg_enable      <= 1'b1;
            state           <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          wait_cnt <= '0;
          state    <= ARB_WAIT;
        end
        ARB_WAIT: begin
          // reg_done is checked first so it wins over a coincident timeout.
          if (reg_done) begin
            req_done  <= grant_oh;
            req_rdata <= reg_read_nwrite ? reg_data_read : 8'h00;
            ptr       <= next_ptr;
            state     <= ARB_IDLE;
          end else if (timeout_hit) begin
            req_done <= grant_oh;
            req_err  <= 1'b1;
            ptr      <= next_ptr;
            state    <= ARB_IDLE;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// tb/tb_ulpi_reg_arbiter.sv - directed self-checking bench for ulpi_reg_arbiter
module tb_ulpi_reg_arbiter;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       req_valid = '0;
  logic [3:0][5:0]  req_addr = '0;
  logic [3:0][7:0]  req_wdata = '0;
  logic [3:0]       req_read_nwrite = '0;
  logic [3:0]       req_done;
  logic             req_err;
  logic [7:0]       req_rdata;
  logic             busy;
  logic [5:0]       reg_addr;
  logic [7:0]       reg_data_write;
  logic             reg_read_nwrite;
  logic             reg_enable;
  logic             reg_done = 1'b0;
  logic [7:0]       reg_data_read = '0;

  int checks = 0;
  int failures = 0;

  ulpi_reg_arbiter #(
    .N_REQ          (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_read_nwrite (req_read_nwrite),
    .req_done        (req_done),
    .req_err         (req_err),
    .req_rdata       (req_rdata),
    .busy            (busy),
    .reg_addr        (reg_addr),
    .reg_data_write  (reg_data_write),
    .reg_read_nwrite (reg_read_nwrite),
    .reg_enable      (reg_enable),
    .reg_done        (reg_done),
    .reg_data_read   (reg_data_read)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on requester r; link answers 2 cycles after reg_enable.
  task automatic txn(input string tag, input int r, input logic [5:0] a, input logic [7:0] d,
                     input logic rnw, input logic [7:0] link_rd);
    logic [3:0] exp_done;
    exp_done = 4'b0001 << r;
    req_addr[r] = a;
    req_wdata[r] = d;
    req_read_nwrite[r] = rnw;
    req_valid[r] = 1'b1;
    tick();
    check({tag, "_en"}, {31'd0, reg_enable}, 32'd1);
    check({tag, "_addr"}, {26'd0, reg_addr}, {26'd0, a});
    check({tag, "_wdata"}, {24'd0, reg_data_write}, {24'd0, d});
    check({tag, "_rnw"}, {31'd0, reg_read_nwrite}, {31'd0, rnw});
    req_valid[r] = 1'b0;
    req_addr[r] = ~a;
    req_wdata[r] = ~d;
    req_read_nwrite[r] = ~rnw;
    tick();
    check({tag, "_en_once"}, {31'd0, reg_enable}, 32'd0);
    tick();
    check({tag, "_addr_hold"}, {26'd0, reg_addr}, {26'd0, a});
    check({tag, "_wdata_hold"}, {24'd0, reg_data_write}, {24'd0, d});
    reg_done = 1'b1;
    reg_data_read = link_rd;
    tick();
    reg_done = 1'b0;
    check({tag, "_done"}, {28'd0, req_done}, {28'd0, exp_done});
    check({tag, "_err"}, {31'd0, req_err}, 32'd0);
    check({tag, "_rdata"}, {24'd0, req_rdata}, rnw ? {24'd0, link_rd} : 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    tick();
    check({tag, "_done_pulse"}, {28'd0, req_done}, 32'd0);
  endtask

  initial begin : main
    logic       early;
    int         waited;
    logic [3:0] exp_done;

    // Reset state
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_en", {31'd0, reg_enable}, 32'd0);
    check("rst_done", {28'd0, req_done}, 32'd0);
    check("rst_addr", {26'd0, reg_addr}, 32'd0);
    reset_n = 1'b1;
    tick();

    txn("wr0", 0, 6'h04, 8'h55, 1'b0, 8'h99);
    txn("rd2", 2, 6'h16, 8'h00, 1'b1, 8'hA7);

    // Fairness: ptr now 3, so point it back at 0 via a transaction on req 3
    txn("wr3", 3, 6'h0A, 8'h12, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 6'h10 + 6'(i);
      req_read_nwrite[i] = 1'b0;
    end
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      waited = 0;
      do begin
        tick();
        waited++;
      end while (!reg_enable && waited < 10);
      check("fair_en", {31'd0, reg_enable}, 32'd1);
      check("fair_order", {26'd0, reg_addr}, 32'h10 + (g % 4));
      if (g > 0) check("fair_b2b", waited, 32'd1);
      tick();
      reg_done = 1'b1;
      tick();
      reg_done = 1'b0;
      exp_done = 4'b0001 << (g % 4);
      check("fair_done", {28'd0, req_done}, {28'd0, exp_done});
      if (g == 4) req_valid = '0;
    end
    tick();
    check("fair_stop", {31'd0, busy}, 32'd0);

    // Timeout on req 1 (ptr is 1 after the fairness run)
    req_addr[1] = 6'h2B;
    req_read_nwrite[1] = 1'b1;
    req_valid[1] = 1'b1;
    tick();
    check("to_en", {31'd0, reg_enable}, 32'd1);
    req_valid[1] = 1'b0;
    early = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (req_done != 4'b0000) early = 1'b1;
    end
    check("to_early", {31'd0, early}, 32'd0);
    check("to_busy", {31'd0, busy}, 32'd1);
    tick();
    check("to_done", {28'd0, req_done}, 32'b0010);
    check("to_err", {31'd0, req_err}, 32'd1);
    check("to_rdata", {24'd0, req_rdata}, 32'd0);
    tick();
    txn("after_to", 3, 6'h31, 8'h00, 1'b1, 8'h5E);

    // reg_done on the timeout cycle wins
    req_addr[2] = 6'h05;
    req_read_nwrite[2] = 1'b1;
    req_valid[2] = 1'b1;
    tick();
    check("col_en", {31'd0, reg_enable}, 32'd1);
    req_valid[2] = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    reg_done = 1'b1;
    reg_data_read = 8'h3C;
    tick();
    reg_done = 1'b0;
    check("col_done", {28'd0, req_done}, 32'b0100);
    check("col_err", {31'd0, req_err}, 32'd0);
    check("col_rdata", {24'd0, req_rdata}, 32'h3C);

    // Stray reg_done in IDLE
    tick();
    reg_done = 1'b1;
    tick(); tick();
    reg_done = 1'b0;
    check("stray_done", {28'd0, req_done}, 32'd0);
    check("stray_busy", {31'd0, busy}, 32'd0);

    // Reset during WAIT
    txn("pre_rst", 3, 6'h01, 8'h01, 1'b0, 8'h00);
    req_addr[0] = 6'h3A;
    req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_addr", {26'd0, reg_addr}, 32'd0);
    check("rst_mid_en", {31'd0, reg_enable}, 32'd0);
    reg_done = 1'b1;
    tick();
    reg_done = 1'b0;
    check("rst_mid_done", {28'd0, req_done}, 32'd0);
    req_addr[1] = 6'h21;
    req_addr[3] = 6'h23;
    req_valid = 4'b1010;
    #2 reset_n = 1'b1;
    tick();
    check("rst_first_grant", {26'd0, reg_addr}, 32'h21);
    req_valid = '0;
    tick();
    reg_done = 1'b1;
    tick();
    reg_done = 1'b0;
    check("rst_first_done", {28'd0, req_done}, 32'b0010);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ulpi_reg_arbiter.md
ULPI_REG_ARBITER -- requirements
Module: ulpi_reg_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of register-access requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum WAIT cycles before abort (1..255).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  in  N_REQ  per-requester transaction request; held until that requester's req_done.
REQ-006 SHALL have port req_addr  in  N_REQ x 6  per-requester ULPI register address.
REQ-007 SHALL have port req_wdata  in  N_REQ x 8  per-requester write data.
REQ-008 SHALL have port req_read_nwrite  in  N_REQ  per-requester 1 = read, 0 = write.
REQ-009 SHALL have port req_done  out  N_REQ  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port req_err  out  1  valid with req_done; 1 = timeout abort.
REQ-011 SHALL have port req_rdata  out  8  read data, valid with req_done.
REQ-012 SHALL have port busy  out  1  high in every state except IDLE.
REQ-013 SHALL have port reg_addr  out  6  to ulpi_link.
REQ-014 SHALL have port reg_data_write  out  8  to ulpi_link.
REQ-015 SHALL have port reg_read_nwrite  out  1  to ulpi_link.
REQ-016 SHALL have port reg_enable  out  1  one-cycle start strobe to ulpi_link.
REQ-017 SHALL have port reg_done  in  1  completion from ulpi_link.
REQ-018 SHALL have port reg_data_read  in  8  read data from ulpi_link, valid with reg_done.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-020 IDLE: when any req_valid is high, SHALL grant one requester round-robin, searching from pointer ptr upward with wrap; SHALL latch its addr/wdata/read_nwrite; next state ISSUE.
REQ-021 Latency: req_valid sampled at edge k SHALL produce reg_enable=1 in the cycle after edge k.
REQ-022 ISSUE: reg_enable SHALL be 1 for exactly one cycle; SHALL clear the timeout counter; next state WAIT.
REQ-023 reg_addr, reg_data_write, reg_read_nwrite SHALL hold the latched values, stable from ISSUE through the end of WAIT.
REQ-024 WAIT: on reg_done=1, SHALL pulse req_done[grant] with req_err=0; on reads SHALL set req_rdata=reg_data_read, on writes req_rdata=0x00; next state IDLE.
REQ-025 WAIT: when the counter reaches TIMEOUT_CYCLES without reg_done, SHALL pulse req_done[grant] with req_err=1, req_rdata=0x00; next state IDLE.
REQ-026 reg_done and timeout in the same cycle: reg_done SHALL win (req_err=0).
REQ-027 reg_done in IDLE or ISSUE SHALL be ignored.
REQ-028 On completion (done or timeout), ptr SHALL become (grant+1) mod N_REQ.
REQ-029 Deasserting req_valid after grant SHALL NOT abort; req_done SHALL still pulse.
REQ-030 Changes to req_* inputs after the grant SHALL NOT affect the transaction in flight.
REQ-031 Minimum transaction time SHALL be 3 cycles (IDLE, ISSUE, WAIT); back-to-back grants SHALL be permitted with no extra idle cycle.
REQ-032 Timeout counter SHALL be 8 bits, saturating, counting only in WAIT.

Reset
REQ-033 reset_n low SHALL asynchronously force state IDLE, ptr 0, counter 0, and all outputs 0 (reg_* outputs, req_done, req_err, req_rdata, busy).
REQ-034 Reset asserted mid-transaction SHALL drop the transaction without a req_done pulse; the first grant after release SHALL search from requester 0.

Structure
REQ-035 Package ulpi_pkg SHALL hold ULPI_REG_ADDR_W=6, typedef ulpi_reg_addr_t, and the arbiter state enum.
REQ-036 Round-robin grant selection SHALL be a sub-module ulpi_rr_arb (combinational request/pointer to one-hot grant plus index).

Verification
REQ-037 Single write: req 0 writes addr 0x04, data 0x55; link returns reg_done 2 cycles after reg_enable -> reg_enable exactly 1 cycle, reg_addr=0x04, reg_data_write=0x55, req_done[0] pulses, req_err=0.
REQ-038 Single read: req 2 reads addr 0x16; link returns reg_data_read=0xA7 with reg_done -> req_done[2] pulses, req_rdata=0xA7.
REQ-039 Fairness: all 4 req_valid held high continuously -> grant order 0,1,2,3,0; no requester granted twice before the other pending requesters.
REQ-040 Timeout: TIMEOUT_CYCLES=8, link never asserts reg_done -> req_done pulses with req_err=1, req_rdata=0x00, exactly 8 WAIT cycles after ISSUE; next request served normally.
REQ-041 Collision and stray: reg_done coincides with the timeout cycle -> req_err=0. Stray reg_done in IDLE -> no req_done pulse.
REQ-042 Reset mid-WAIT: reset_n pulsed low during WAIT -> all outputs 0 immediately, no req_done pulse; after release with req 3 and req 1 both valid, req 1 is granted first.
